theta_position_updater: RTL and testbench
=========================================

Name: theta_position_updater

Overview:
- Downstream stage of the theta accumulator control path.
- When the accumulator signals completion, this block takes the normalized heading theta (degrees, 0..359) and quantizes it to one of 8 compass sectors by iterative subtraction.
- It then advances the cruiser's (x, y) position by SPEED pixels in that direction, with toroidal wrap-around at the play-field edges.
- It pulses done for one cycle so the game/render controller can sample the new position.

Parameters:
- COORD_W, 8, width of x/y coordinates.
- X_MAX, 160, field width; x is kept in 0..X_MAX-1.
- Y_MAX, 120, field height; y is kept in 0..Y_MAX-1.
- X_INIT, 80, x value after reset.
- Y_INIT, 60, y value after reset.
- SPEED, 2, pixels moved per axis per update; must satisfy 0 < SPEED < min(X_MAX, Y_MAX).

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; returns the block to IDLE with reset values.
- start  input  1  update request, level-sampled in IDLE (driven by the accumulator's done pulse).
- theta  input  9  heading in degrees; 0..359 nominal, any 9-bit value accepted.
- x  output  COORD_W  current x position, registered.
- y  output  COORD_W  current y position, registered.
- sector  output  3  last computed sector 0..7, registered.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; x/y/sector are already valid when it is high.

Behaviour:
- Reset (async):
  - state=IDLE, x=X_INIT, y=Y_INIT, sector=0, busy=0, done=0.
  - Internal t=0, cnt=0.
  - Reset mid-operation aborts with no done pulse and no position change.
- FSM states: IDLE, DIVIDE, UPDATE, DONE. busy and done are Moore outputs: busy = (state!=IDLE), done = (state==DONE).
- IDLE:
  - On an edge with start=1: latch t = theta + 22 (10-bit, no overflow), cnt=0, go DIVIDE.
  - start=0: stay in IDLE.
- DIVIDE:
  - If t >= 45: t -= 45, cnt += 1 (3-bit, wraps modulo 8), stay in DIVIDE.
  - Else: go UPDATE.
  - k = floor((theta+22)/45) subtraction cycles, then one exit cycle.
- UPDATE (one cycle):
  - sector <= cnt.
  - x <= wrapX(x + dx*SPEED), y <= wrapY(y + dy*SPEED).
  - Go DONE.
- DONE (one cycle): done=1, go IDLE.
- Latency: the start-sampling edge is E0. The state is UPDATE after edge E0+k+1. done is high, with x/y/sector updated, in the cycle after edge E0+k+2. Back in IDLE after E0+k+3. Examples: theta=0 gives 2 cycles; theta=359 gives 10 cycles.
- Sector to (dx,dy), y positive = up: 0:(+1,0), 1:(+1,+1), 2:(0,+1), 3:(-1,+1), 4:(-1,0), 5:(-1,-1), 6:(0,-1), 7:(+1,-1).
- Sector boundaries: sector n covers theta in [45n-22, 45n+22]. theta 338..359 maps to sector 0 via cnt wrap (cnt reaches 8, which is 0 mod 8).
- Wrap arithmetic:
  - Compute in COORD_W+2 signed bits: s = pos + d.
  - If s >= MAX: s - MAX. If s < 0: s + MAX. Otherwise s.
  - Result always lies in 0..MAX-1.
- start while busy: ignored (not queued). A start held high in the DONE cycle is sampled only in the following IDLE cycle.
- theta >= 360: processed by the same loop. Maximum t = 533, k = 11, cnt wraps. Example: theta=400 gives t=422, k=9, cnt=1, sector 1.
- x, y and sector hold their values in all states except UPDATE.

Decomposition:
- Shared package cruiser_pkg:
  - FSM state localparams (2-bit encoding).
  - SECTOR_SPAN=45, SECTOR_OFFSET=22.
  - 8-entry dx/dy direction constants.
- Sub-module coord_wrap:
  - Parameters COORD_W and MAX.
  - Combinational signed add of pos + step with the single-correction wrap above.
  - Instantiated twice (x axis, y axis); the registers stay in the top.

Test Plan:
- Reset asserted mid-idle -> x=80, y=60, sector=0, busy=0, done=0 asynchronously, before the next clk edge.
- theta=0, one-cycle start pulse -> busy next cycle; done high exactly 2 cycles after the sampling edge; x=82, y=60, sector=0.
- theta=100 (t=122, k=2) -> done 4 cycles after start; sector=2; x=80, y=62. Then theta=225 -> sector=5; x=78, y=60.
- theta=359 and theta=337 -> sector=0 (done at 10 cycles, x+2) and sector=7 (x+2, y-2) respectively.
- Edge wrap with X_INIT=0, Y_INIT=119 -> theta=180 gives x=158; then theta=90 gives y=1.
- start held high continuously -> updates back-to-back, one per pass with an IDLE cycle between, no extra done pulses. Separately, reset asserted in DIVIDE -> no done pulse, x/y at init values, state IDLE.

Source files
------------

// File: rtl/cruiser_pkg.sv
// Shared definitions for the cruiser position path: FSM encoding, sector
// quantisation constants and the compass direction table.
package cruiser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int SECTOR_SPAN   = 45;
  localparam int SECTOR_OFFSET = 22;

  // Unit step along x for each of the 8 compass sectors (sector 0 = east).
  function automatic logic signed [1:0] sector_dx(input logic [2:0] s);
    logic signed [1:0] d;
    case (s)
      3'd0, 3'd1, 3'd7: d = 2'sd1;
      3'd3, 3'd4, 3'd5: d = -2'sd1;
      default:          d = 2'sd0;
    endcase
    return d;
  endfunction

  // Unit step along y; positive y points up.
  function automatic logic signed [1:0] sector_dy(input logic [2:0] s);
    logic signed [1:0] d;
    case (s)
      3'd1, 3'd2, 3'd3: d = 2'sd1;
      3'd5, 3'd6, 3'd7: d = -2'sd1;
      default:          d = 2'sd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/coord_wrap.sv
// Toroidal coordinate step: pos + step folded back into 0..MAX-1 with a
// single correction, valid while |step| < MAX.
module coord_wrap #(
  parameter int COORD_W = 8,
  parameter int MAX     = 160
) (
  input  logic [COORD_W-1:0]        pos,
  input  logic signed [COORD_W+1:0] step,
  output logic [COORD_W-1:0]        wrapped
);

  localparam logic signed [COORD_W+1:0] MAX_S = (COORD_W+2)'(MAX);

  logic signed [COORD_W+1:0] sum;
  logic signed [COORD_W+1:0] fixed;

  always_comb begin
    sum = $signed({2'b00, pos}) + step;
    if (sum >= MAX_S) begin
      fixed = sum - MAX_S;
    end else if (sum[COORD_W+1]) begin
      fixed = sum + MAX_S;
    end else begin
      fixed = sum;
    end
    wrapped = COORD_W'(fixed);
  end

endmodule

// File: rtl/theta_position_updater.sv
// Quantises a heading to one of 8 compass sectors by repeated subtraction,
// then advances the cruiser position one SPEED step with toroidal wrap.
module theta_position_updater
  import cruiser_pkg::*;
#(
  parameter int COORD_W = 8,
  parameter int X_MAX   = 160,
  parameter int Y_MAX   = 120,
  parameter int X_INIT  = 80,
  parameter int Y_INIT  = 60,
  parameter int SPEED   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [8:0]         theta,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [2:0]         sector,
  output logic               busy,
  output logic               done
);

  // Handshake: start is a level request sampled only while idle (busy=0);
  // requests while busy are dropped. done pulses one cycle with x/y/sector
  // already holding the new result; there is no back-pressure.

  localparam logic [9:0] SPAN_W   = 10'(SECTOR_SPAN);
  localparam logic [9:0] OFFSET_W = 10'(SECTOR_OFFSET);
  localparam logic signed [COORD_W+1:0] SPEED_S = (COORD_W+2)'(SPEED);

  state_t state, state_nxt;
  logic [9:0] t;
  logic [2:0] cnt;

  logic signed [COORD_W+1:0] step_x, step_y;
  logic [COORD_W-1:0] x_next, y_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_DIVIDE;
      ST_DIVIDE: if (t < SPAN_W) state_nxt = ST_UPDATE;
      ST_UPDATE: state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // The offset shifts sector boundaries so each sector is centred on 45n;
  // cnt wraps mod 8 so headings near 360 land back in sector 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t      <= '0;
      cnt    <= '0;
      x      <= COORD_W'(X_INIT);
      y      <= COORD_W'(Y_INIT);
      sector <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            t   <= {1'b0, theta} + OFFSET_W;
            cnt <= '0;
          end
        end
        ST_DIVIDE: begin
          if (t >= SPAN_W) begin
            t   <= t - SPAN_W;
            cnt <= cnt + 3'd1;
          end
        end
        ST_UPDATE: begin
          sector <= cnt;
          x      <= x_next;
          y      <= y_next;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    step_x = '0;
    step_y = '0;
    if (sector_dx(cnt) == 2'sd1) begin
      step_x = SPEED_S;
    end else if (sector_dx(cnt) == -2'sd1) begin
      step_x = -SPEED_S;
    end
    if (sector_dy(cnt) == 2'sd1) begin
      step_y = SPEED_S;
    end else if (sector_dy(cnt) == -2'sd1) begin
      step_y = -SPEED_S;
    end
  end

  coord_wrap #(.COORD_W(COORD_W), .MAX(X_MAX)) u_wrap_x (
    .pos     (x),
    .step    (step_x),
    .wrapped (x_next)
  );

  coord_wrap #(.COORD_W(COORD_W), .MAX(Y_MAX)) u_wrap_y (
    .pos     (y),
    .step    (step_y),
    .wrapped (y_next)
  );

endmodule

// File: tb/tb_theta_position_updater.sv
// Bench for theta_position_updater: a default instance and an edge-start
// instance, both checked every cycle against a countdown/modulo model.
module tb_theta_position_updater;

  logic clk = 1'b0;
  logic reset;
  logic start0, start1;
  logic [8:0] theta0, theta1;
  logic [7:0] x0, y0, x1, y1;
  logic [2:0] sec0, sec1;
  logic busy0, busy1, done0, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  theta_position_updater dut0 (
    .clk(clk), .reset(reset), .start(start0), .theta(theta0),
    .x(x0), .y(y0), .sector(sec0), .busy(busy0), .done(done0)
  );

  theta_position_updater #(.X_INIT(0), .Y_INIT(119)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .theta(theta1),
    .x(x1), .y(y1), .sector(sec1), .busy(busy1), .done(done1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int xi[2] = '{80, 0};
  int yi[2] = '{60, 119};
  int m_left[2], m_x[2], m_y[2], m_sec[2], p_x[2], p_y[2], p_sec[2];

  function automatic int dir_x(input int s);
    if (s == 0 || s == 1 || s == 7) return 1;
    if (s == 3 || s == 4 || s == 5) return -1;
    return 0;
  endfunction

  function automatic int dir_y(input int s);
    if (s == 1 || s == 2 || s == 3) return 1;
    if (s == 5 || s == 6 || s == 7) return -1;
    return 0;
  endfunction

  // m_left counts edges until the unit is idle again; done is visible when
  // it reads 1, and the new position appears at that same edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_left[i] = 0;
        m_x[i] = xi[i];
        m_y[i] = yi[i];
        m_sec[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int st, th, k;
        st = (i == 0) ? int'(start0) : int'(start1);
        th = (i == 0) ? int'(theta0) : int'(theta1);
        if (m_left[i] == 0) begin
          if (st != 0) begin
            k = (th + 22) / 45;
            p_sec[i] = k % 8;
            p_x[i] = (m_x[i] + 2 * dir_x(p_sec[i]) + 160) % 160;
            p_y[i] = (m_y[i] + 2 * dir_y(p_sec[i]) + 120) % 120;
            m_left[i] = k + 3;
          end
        end else begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 1) begin
            m_x[i] = p_x[i];
            m_y[i] = p_y[i];
            m_sec[i] = p_sec[i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("dut0_x", int'(x0), m_x[0]);
    check("dut0_y", int'(y0), m_y[0]);
    check("dut0_sector", int'(sec0), m_sec[0]);
    check("dut0_busy", int'(busy0), int'(m_left[0] != 0));
    check("dut0_done", int'(done0), int'(m_left[0] == 1));
    check("dut1_x", int'(x1), m_x[1]);
    check("dut1_y", int'(y1), m_y[1]);
    check("dut1_sector", int'(sec1), m_sec[1]);
    check("dut1_busy", int'(busy1), int'(m_left[1] != 0));
    check("dut1_done", int'(done1), int'(m_left[1] == 1));
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input int idx, input logic st, input int th);
    if (idx == 0) begin
      start0 = st;
      theta0 = 9'(th);
    end else begin
      start1 = st;
      theta1 = 9'(th);
    end
  endtask

  task automatic run_op(input int idx, input int th, output int lat);
    logic b, d;
    @(posedge clk);
    #1 set_in(idx, 1'b1, th);
    @(posedge clk);
    #1 set_in(idx, 1'b0, th);
    b = (idx == 0) ? busy0 : busy1;
    check("busy_after_start", int'(b), 1);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      d = (idx == 0) ? done0 : done1;
      if (d) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  int lat;
  int pulses;

  initial begin
    reset = 1'b1;
    set_in(0, 1'b0, 0);
    set_in(1, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_x0", int'(x0), 80);
    check("rst_y0", int'(y0), 60);
    check("rst_sec0", int'(sec0), 0);
    check("rst_busy0", int'(busy0), 0);
    check("rst_done0", int'(done0), 0);
    check("rst_x1", int'(x1), 0);
    check("rst_y1", int'(y1), 119);
    reset = 1'b0;

    run_op(0, 0, lat);
    check("lat_theta0", lat, 2);
    check("x_theta0", int'(x0), 82);
    check("y_theta0", int'(y0), 60);
    check("sec_theta0", int'(sec0), 0);

    // asynchronous reset between clock edges while idle
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_x0", int'(x0), 80);
    check("async_rst_y0", int'(y0), 60);
    check("async_rst_busy0", int'(busy0), 0);
    #1 reset = 1'b0;

    run_op(0, 100, lat);
    check("lat_theta100", lat, 4);
    check("sec_theta100", int'(sec0), 2);
    check("x_theta100", int'(x0), 80);
    check("y_theta100", int'(y0), 62);

    run_op(0, 225, lat);
    check("sec_theta225", int'(sec0), 5);
    check("x_theta225", int'(x0), 78);
    check("y_theta225", int'(y0), 60);

    run_op(0, 359, lat);
    check("lat_theta359", lat, 10);
    check("sec_theta359", int'(sec0), 0);
    check("x_theta359", int'(x0), 80);

    run_op(0, 337, lat);
    check("sec_theta337", int'(sec0), 7);
    check("x_theta337", int'(x0), 82);
    check("y_theta337", int'(y0), 58);

    run_op(0, 400, lat);
    check("lat_theta400", lat, 11);
    check("sec_theta400", int'(sec0), 1);

    run_op(1, 180, lat);
    check("wrap_x_theta180", int'(x1), 158);
    check("wrap_y_theta180", int'(y1), 119);
    run_op(1, 90, lat);
    check("wrap_y_theta90", int'(y1), 1);
    check("wrap_x_theta90", int'(x1), 158);

    // start held high: one pass every k+4 edges, theta=0 gives k=0
    @(posedge clk);
    #1 set_in(0, 1'b1, 0);
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done0) pulses++;
    end
    set_in(0, 1'b0, 0);
    check("held_start_pulses", pulses, 5);
    repeat (4) @(posedge clk);

    // reset while dividing aborts without a done pulse
    @(posedge clk);
    #1 set_in(0, 1'b1, 359);
    @(posedge clk);
    #1 set_in(0, 1'b0, 359);
    @(posedge clk);
    #1;
    check("divide_busy", int'(busy0), 1);
    #2 reset = 1'b1;
    #1;
    check("abort_x0", int'(x0), 80);
    check("abort_y0", int'(y0), 60);
    check("abort_busy0", int'(busy0), 0);
    check("abort_done0", int'(done0), 0);
    #1 reset = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done0) pulses++;
    end
    check("abort_no_done", pulses, 0);

    // randomized traffic on both instances, including starts while busy
    repeat (1500) begin
      @(posedge clk);
      #1;
      set_in(0, 1'($urandom_range(0, 2) == 0), $urandom_range(0, 511));
      set_in(1, 1'($urandom_range(0, 1)), $urandom_range(0, 511));
    end
    #0 set_in(0, 1'b0, 0);
    set_in(1, 1'b0, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
